// File: rtl/cic_comp_fir.sv
// -----------------------------------------------------------------------------
// cic_comp_fir
//   Decimate-by-2 compensation FIR placed after a CIC decimator. Each accepted
//   sample shifts into a TAPS-deep delay line. Every second accepted sample
//   triggers a MAC pass. The pass runs serially (one tap per clock) on a
//   snapshot of the delay line, so the line can keep filling while the pass
//   runs. The rounded result is saturated or wrapped to DATA_WIDTH.
//
//   Build option:
//     CIC_COMP_SAT_EN  defined   -> the rounded result saturates to DATA_WIDTH
//                      undefined -> the rounded result wraps (keeps its LSBs)
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low reset
//   in_data      in   [DATA_WIDTH-1:0] signed sample from the CIC
//   in_valid     in   one-cycle strobe; in_data is taken when high
//   out_data     out  [DATA_WIDTH-1:0] compensated sample (held between strobes)
//   out_valid    out  one-cycle strobe for out_data
//   busy         out  high while a MAC pass is running
//   overrun      out  sticky: a trigger arrived while a pass was running
//   overrun_clr  in   synchronous clear for overrun
// -----------------------------------------------------------------------------
module cic_comp_fir #(
  parameter int DATA_WIDTH = 15,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter logic [TAPS*COEF_WIDTH-1:0] COEFS = {
    -16'sd512, 16'sd1024, 16'sd4096, 16'sd12288,
    16'sd12288, 16'sd4096, 16'sd1024, -16'sd512
  }
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS);
  // Width left after dropping the COEF_WIDTH-1 fractional bits.
  localparam int RND_W  = ACC_W - COEF_WIDTH + 1;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (COEF_WIDTH - 2);

`ifdef CIC_COMP_SAT_EN
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-(2 ** (DATA_WIDTH - 1)));
`endif

  // Round half up, then drop the fractional coefficient bits.
  function automatic logic signed [RND_W-1:0] f_round(input logic signed [ACC_W-1:0] a);
    return RND_W'((a + HALF) >>> (COEF_WIDTH - 1));
  endfunction

  // Reduce the rounded value to the output width.
  function automatic logic signed [DATA_WIDTH-1:0] f_reduce(input logic signed [RND_W-1:0] r);
`ifdef CIC_COMP_SAT_EN
    if (r > SAT_MAX) begin
      return DATA_WIDTH'(SAT_MAX);
    end else if (r < SAT_MIN) begin
      return DATA_WIDTH'(SAT_MIN);
    end else begin
      return DATA_WIDTH'(r);
    end
`else
    return DATA_WIDTH'(r);
`endif
  endfunction

  logic signed [DATA_WIDTH-1:0] r_dline [TAPS];
  logic signed [DATA_WIDTH-1:0] r_snap  [TAPS];
  logic signed [COEF_WIDTH-1:0] w_coef  [TAPS];

  logic                         r_phase;
  logic                         r_busy;
  logic                         r_last;
  logic [IDX_W-1:0]             r_idx;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [DATA_WIDTH-1:0] r_out;
  logic                         r_out_valid;
  logic                         r_overrun;

  logic                         w_trig;
  logic                         w_done;
  logic                         w_start;
  logic                         w_ovr_set;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]      w_prod_ext;

  for (genvar g = 0; g < TAPS; g++) begin : g_coef
    assign w_coef[g] = COEFS[g*COEF_WIDTH +: COEF_WIDTH];
  end

  assign w_trig    = in_valid & r_phase;
  // r_last marks the cycle after the final MAC: the result is written out and
  // the pass ends on this edge.
  assign w_done    = r_busy & r_last;
  // A trigger landing on the busy-clear edge starts the next pass directly.
  assign w_start   = w_trig & (~r_busy | w_done);
  assign w_ovr_set = w_trig & r_busy & ~w_done;

  assign w_prod     = PROD_W'(w_coef[r_idx]) * PROD_W'(r_snap[r_idx]);
  assign w_prod_ext = ACC_W'(w_prod);

  // Input stage: delay line and decimation phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_dline[i] <= '0;
      r_phase <= 1'b0;
    end else if (in_valid) begin
      r_dline[0] <= in_data;
      for (int i = 1; i < TAPS; i++) r_dline[i] <= r_dline[i-1];
      r_phase <= ~r_phase;
    end
  end

  // Snapshot stage: capture the post-shift line so the MAC is isolated from
  // samples that arrive during the pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_snap[i] <= '0;
    end else if (w_start) begin
      r_snap[0] <= in_data;
      for (int i = 1; i < TAPS; i++) r_snap[i] <= r_dline[i-1];
    end
  end

  // MAC stage: one tap per clock, then round and reduce into the output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_last      <= 1'b0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_start) begin
        r_busy <= 1'b1;
        r_last <= 1'b0;
        r_idx  <= '0;
        r_acc  <= '0;
      end else if (w_done) begin
        r_busy <= 1'b0;
      end else if (r_busy) begin
        r_acc <= r_acc + w_prod_ext;
        if (r_idx == IDX_W'(TAPS - 1)) begin
          r_last <= 1'b1;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (w_done) begin
        r_out       <= f_reduce(f_round(r_acc));
        r_out_valid <= 1'b1;
      end
    end
  end

  // Overrun flag: a new event takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_cic_comp_fir.sv
// -----------------------------------------------------------------------------
// tb_cic_comp_fir
//   Self-checking bench for cic_comp_fir with default parameters.
//   A reference model tracks the accepted samples, the decimation phase and the
//   time at which each MAC pass finishes. It predicts every out_valid strobe
//   (value and cycle), busy, overrun and the held out_data. Directed sequences
//   and a constant-input table cover the corner cases. A random run follows.
// -----------------------------------------------------------------------------
module tb_cic_comp_fir;

  localparam int DW   = 15;
  localparam int CW   = 16;
  localparam int TAPS = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  cic_comp_fir dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int coef [TAPS] = '{-512, 1024, 4096, 12288, 12288, 4096, 1024, -512};
  int hist [TAPS];
  bit m_phase = 1'b0;
  bit m_ovr = 1'b0;
  int m_free_edge = 0;   // first edge at which no pass is running
  int cyc = 0;           // number of rising edges seen
  int last_out = 0;

  typedef struct {int y; int at;} exp_t;
  exp_t exp_q[$];
  int   got_q[$];
  exp_t ce;

  function automatic int ref_out();
    longint s;
    longint y;
    int     w;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(coef[i]) * longint'(hist[i]);
    y = (s + 64'sd16384) >>> 15;
`ifdef CIC_COMP_SAT_EN
    if (y > 16383) y = 16383;
    if (y < -16384) y = -16384;
    return int'(y);
`else
    w = int'(y & 64'sd32767);
    if (w >= 16384) w -= 32768;
    return w;
`endif
  endfunction

  // Drive one clock's worth of inputs and advance the model for that edge.
  task automatic step(input bit v, input int d, input bit clr);
    int e;
    bit trig;
    bit acc;
    @(negedge clk);
    in_valid    = v;
    in_data     = DW'(d);
    overrun_clr = clr;
    e    = cyc + 1;
    trig = 1'b0;
    acc  = 1'b0;
    if (v) begin
      for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = d;
      if (m_phase) begin
        trig = 1'b1;
        if (e >= m_free_edge) begin
          acc = 1'b1;
          exp_q.push_back('{ref_out(), e + TAPS + 1});
          m_free_edge = e + TAPS + 1;
        end
      end
      m_phase = ~m_phase;
    end
    if (trig && !acc) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    overrun_clr = 1'b0;
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    m_phase     = 1'b0;
    m_ovr       = 1'b0;
    m_free_edge = 0;
    exp_q.delete();
    last_out    = 0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'($signed(out_data)), 0);
    check("rst_overrun", int'(overrun), 0);
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  // Per-cycle checker, sampling 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    check("busy", int'(busy), int'(cyc < m_free_edge));
    check("overrun", int'(overrun), int'(m_ovr));
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      ce = exp_q.pop_front();
      check("out_valid_due", int'(out_valid), 1);
      if (out_valid) check("out_data", int'($signed(out_data)), ce.y);
    end else begin
      check("out_valid_idle", int'(out_valid), 0);
    end
    if (out_valid) begin
      last_out = int'($signed(out_data));
      got_q.push_back(last_out);
    end else begin
      check("out_hold", int'($signed(out_data)), last_out);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {int x; int want;} vec_t;
  vec_t vecs[8];
  int   imp_exp[5] = '{-128, 1024, 3072, 256, 0};

  initial begin
    // Constant input x for 8 samples -> x * 33792/32768 rounded half up.
`ifdef CIC_COMP_SAT_EN
    vecs = '{'{0, 0}, '{16383, 16383}, '{-16384, -16384}, '{1000, 1031},
             '{-1000, -1031}, '{16, 17}, '{-16, -16}, '{15888, 16383}};
`else
    vecs = '{'{0, 0}, '{16383, -15873}, '{-16384, 15872}, '{1000, 1031},
             '{-1000, -1031}, '{16, 17}, '{-16, -16}, '{15888, -16383}};
`endif

    pulse_reset(3);

    // Table: DC levels including rounding ties and the range edges.
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 8; s++) begin
        step(1'b1, vecs[k].x, 1'b0);
        idle(9);
      end
      idle(2);
      check("dc_table", last_out, vecs[k].want);
    end

    // Impulse: 8192 as the 2nd of 10 samples, one sample every 10 clocks.
    pulse_reset(2);
    got_q.delete();
    for (int n = 1; n <= 10; n++) begin
      step(1'b1, (n == 2) ? 8192 : 0, 1'b0);
      idle(9);
    end
    idle(3);
    check("impulse_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check("impulse_val", got_q[i], imp_exp[i]);

    // Back-to-back samples: later triggers are dropped and overrun sticks.
    pulse_reset(2);
    for (int n = 0; n < 6; n++) step(1'b1, 500 * n - 1000, 1'b0);
    idle(12);
    check("overrun_set", int'(overrun), 1);
    step(1'b0, 0, 1'b1);
    idle(1);
    check("overrun_clr", int'(overrun), 0);

    // Clear and a new overrun event on the same edge: overrun stays set.
    pulse_reset(2);
    step(1'b1, 10, 1'b0);
    step(1'b1, 20, 1'b0);
    step(1'b1, 30, 1'b0);
    step(1'b1, 40, 1'b1);
    step(1'b0, 0, 1'b0);
    check("overrun_clr_vs_set", int'(overrun), 1);
    idle(12);

    // Reset during a MAC pass aborts it; no strobe until two new samples.
    pulse_reset(2);
    step(1'b1, 100, 1'b0);
    step(1'b1, 200, 1'b0);
    idle(3);
    got_q.delete();
    pulse_reset(2);
    idle(15);
    check("no_out_after_reset", got_q.size(), 0);
    step(1'b1, 300, 1'b0);
    idle(9);
    step(1'b1, 400, 1'b0);
    idle(12);
    check("out_after_reset", got_q.size(), 1);

    // Samples every TAPS+1 clocks: every pass accepted, no overrun.
    pulse_reset(2);
    got_q.delete();
    for (int n = 0; n < 12; n++) begin
      step(1'b1, 1200 * n - 7000, 1'b0);
      idle(8);
    end
    idle(12);
    check("period9_overrun", int'(overrun), 0);
    check("period9_count", got_q.size(), 6);

    // Sample gaps 4/5: each trigger lands exactly on the busy-clear edge.
    pulse_reset(2);
    got_q.delete();
    for (int n = 0; n < 12; n++) begin
      step(1'b1, 900 * n - 5000, 1'b0);
      idle((n % 2 == 0) ? 3 : 4);
    end
    idle(12);
    check("trig_on_clear_overrun", int'(overrun), 0);
    check("trig_on_clear_count", got_q.size(), 6);

    // Random traffic against the model.
    pulse_reset(2);
    for (int n = 0; n < 1500; n++) begin
      step(($urandom % 3) == 0, int'($urandom_range(0, 32767)) - 16384, ($urandom % 20) == 0);
    end
    idle(12);
    check("random_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
